// File: rtl/fir_da_pkg.sv
// Shared constants, state encoding and LUT-build helper for the
// multi-channel distributed-arithmetic FIR.
package fir_da_pkg;

   localparam int COEF_WIDTH = 8;
   localparam int NTAPS      = 8;
   localparam int LUT_W      = COEF_WIDTH + 2;

   typedef logic signed [COEF_WIDTH-1:0] coef_t;

   localparam coef_t C [NTAPS] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4,
                                   8'sd4, 8'sd3, 8'sd2, 8'sd1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Partial sum of the four coefficients starting at base selected by addr.
   function automatic logic signed [LUT_W-1:0] lut_entry(input int base,
                                                         input logic [3:0] addr);
      logic signed [LUT_W-1:0] sum_v;
      sum_v = '0;
      for (int j = 0; j < 4; j++) begin
         if (addr[j]) begin
            sum_v = sum_v + LUT_W'(C[3'(base + j)]);
         end else begin
            sum_v = sum_v;
         end
      end
      return sum_v;
   endfunction

endpackage

// File: rtl/fir_da_lut.sv
// 16-entry partial-sum table over four consecutive package coefficients.
module fir_da_lut
   import fir_da_pkg::*;
#(
   parameter int BASE = 0
) (
   input  logic [3:0]              addr,
   output logic signed [LUT_W-1:0] psum
);

   logic signed [LUT_W-1:0] table_s [16];

   for (genvar a = 0; a < 16; a++) begin : g_tab
      assign table_s[a] = lut_entry(BASE, 4'(a));
   end

   assign psum = table_s[addr];

endmodule

// File: rtl/fir_da_mch.sv
// Multi-channel 8-tap FIR using MSB-first bit-serial distributed arithmetic:
// one bit-plane per cycle, two 4-tap LUTs summed into a shift accumulator.
module fir_da_mch
   import fir_da_pkg::*;
#(
   parameter int IDATA_WIDTH = 12,
   parameter int ODATA_WIDTH = 16,
   parameter int NCH         = 2,
   parameter int OUT_SHIFT   = 0
) (
   input  logic                   sys_clk,
   input  logic                   sys_rstn,
   input  logic [IDATA_WIDTH-1:0] fir_lp_in,
   input  logic [2:0]             in_ch,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   clr,
   output logic [ODATA_WIDTH-1:0] fir_lp_out,
   output logic [2:0]             out_ch,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   ch_err
);

   localparam int ACC_W = IDATA_WIDTH + COEF_WIDTH + 3;
   localparam int SUM_W = LUT_W + 1;
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int BIT_W = (IDATA_WIDTH > 1) ? $clog2(IDATA_WIDTH) : 1;
   localparam int SAT_W = ((ACC_W > ODATA_WIDTH) ? ACC_W : ODATA_WIDTH) + 1;

   localparam logic [3:0]              NCH_C  = 4'(NCH);
   localparam logic [BIT_W-1:0]        MSB_C  = BIT_W'(IDATA_WIDTH - 1);
   localparam logic signed [SAT_W-1:0] OMAX_C = {{(SAT_W-ODATA_WIDTH+1){1'b0}},
                                                 {(ODATA_WIDTH-1){1'b1}}};
   localparam logic signed [SAT_W-1:0] OMIN_C = {{(SAT_W-ODATA_WIDTH+1){1'b1}},
                                                 {(ODATA_WIDTH-1){1'b0}}};

   state_t                  state_r;
   logic [IDATA_WIDTH-1:0]  dl_r [NCH][NTAPS];
   logic [2:0]              ch_r;
   logic [BIT_W-1:0]        bit_r;
   logic                    last_r;
   logic signed [ACC_W-1:0] acc_r;

   logic [3:0]              addr_lo_s;
   logic [3:0]              addr_hi_s;
   logic signed [LUT_W-1:0] psum_lo_s;
   logic signed [LUT_W-1:0] psum_hi_s;
   logic signed [SUM_W-1:0] plane_sum_s;
   logic signed [ACC_W-1:0] acc_next_s;
   logic signed [ACC_W-1:0] shifted_s;
   logic signed [SAT_W-1:0] wide_s;
   logic [ODATA_WIDTH-1:0]  sat_s;
   logic                    xfer_s;
   logic                    ch_ok_s;

   assign in_ready = (state_r == IDLE) && !clr;
   assign xfer_s   = in_valid && in_ready;
   assign ch_ok_s  = ({1'b0, in_ch} < NCH_C);

   // Gather the current bit-plane of the active channel's taps.
   always_comb begin
      addr_lo_s = '0;
      addr_hi_s = '0;
      for (int k = 0; k < 4; k++) begin
         addr_lo_s[k] = dl_r[ch_r[CH_W-1:0]][3'(k)][bit_r];
         addr_hi_s[k] = dl_r[ch_r[CH_W-1:0]][3'(k + 4)][bit_r];
      end
   end

   fir_da_lut #(.BASE(0)) u_lut_lo (.addr(addr_lo_s), .psum(psum_lo_s));
   fir_da_lut #(.BASE(4)) u_lut_hi (.addr(addr_hi_s), .psum(psum_hi_s));

   // Sign plane enters negated; later planes use the Horner step 2*acc + sum.
   always_comb begin
      plane_sum_s = SUM_W'(psum_lo_s) + SUM_W'(psum_hi_s);
      if (bit_r == MSB_C) begin
         acc_next_s = -ACC_W'(plane_sum_s);
      end else begin
         acc_next_s = (acc_r <<< 1'b1) + ACC_W'(plane_sum_s);
      end
   end

   // Arithmetic scale then clamp to the output range.
   always_comb begin
      shifted_s = acc_r >>> OUT_SHIFT;
      wide_s    = SAT_W'(shifted_s);
      if (wide_s > OMAX_C) begin
         sat_s = OMAX_C[ODATA_WIDTH-1:0];
      end else if (wide_s < OMIN_C) begin
         sat_s = OMIN_C[ODATA_WIDTH-1:0];
      end else begin
         sat_s = wide_s[ODATA_WIDTH-1:0];
      end
   end

   // Control FSM, delay lines, accumulator and registered outputs.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_r    <= IDLE;
         for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < NTAPS; k++) begin
               dl_r[c][k] <= '0;
            end
         end
         ch_r       <= 3'd0;
         bit_r      <= '0;
         last_r     <= 1'b0;
         acc_r      <= '0;
         fir_lp_out <= '0;
         out_ch     <= 3'd0;
         out_valid  <= 1'b0;
         ch_err     <= 1'b0;
      end else if (clr) begin
         state_r   <= IDLE;
         for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < NTAPS; k++) begin
               dl_r[c][k] <= '0;
            end
         end
         last_r    <= 1'b0;
         out_valid <= 1'b0;
         ch_err    <= 1'b0;
      end else begin
         ch_err <= 1'b0;
         case (state_r)
            IDLE: begin
               if (xfer_s) begin
                  if (ch_ok_s) begin
                     for (int k = NTAPS - 1; k > 0; k--) begin
                        dl_r[in_ch[CH_W-1:0]][k] <= dl_r[in_ch[CH_W-1:0]][k-1];
                     end
                     dl_r[in_ch[CH_W-1:0]][0] <= fir_lp_in;
                     ch_r    <= in_ch;
                     bit_r   <= MSB_C;
                     last_r  <= 1'b0;
                     state_r <= CALC;
                  end else begin
                     ch_err <= 1'b1;
                  end
               end
            end
            CALC: begin
               if (last_r) begin
                  fir_lp_out <= sat_s;
                  out_ch     <= ch_r;
                  out_valid  <= 1'b1;
                  last_r     <= 1'b0;
                  state_r    <= HOLD;
               end else begin
                  acc_r <= acc_next_s;
                  if (bit_r == '0) begin
                     last_r <= 1'b1;
                  end else begin
                     bit_r <= bit_r - 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r   <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_da_mch.sv
// Directed self-checking bench for fir_da_mch with hand-computed expectations.
module tb_fir_da_mch;

   logic        sys_clk = 1'b0;
   logic        sys_rstn;
   logic [11:0] fir_lp_in;
   logic [2:0]  in_ch;
   logic        in_valid;
   logic        in_ready;
   logic        clr;
   logic [15:0] fir_lp_out;
   logic [2:0]  out_ch;
   logic        out_valid;
   logic        out_ready;
   logic        ch_err;

   int checks = 0;
   int errors = 0;

   int imp_exp [9] = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
   int pos_exp [8] = '{2047, 6141, 12282, 20470, 28658, 32767, 32767, 32767};
   int neg_exp [8] = '{-2048, -6144, -12288, -20480, -28672, -32768, -32768, -32768};
   int iso_exp [8] = '{100, 200, 300, 400, 400, 300, 200, 100};

   always #5 sys_clk = ~sys_clk;

   fir_da_mch #(
      .IDATA_WIDTH(12),
      .ODATA_WIDTH(16),
      .NCH(2),
      .OUT_SHIFT(0)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rstn(sys_rstn),
      .fir_lp_in(fir_lp_in),
      .in_ch(in_ch),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .clr(clr),
      .fir_lp_out(fir_lp_out),
      .out_ch(out_ch),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .ch_err(ch_err)
   );

   task automatic chk(input string tag, input logic signed [63:0] got,
                      input logic signed [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send(input logic [2:0] ch, input logic [11:0] x);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      chk("send_ready", in_ready, 1);
      in_valid  = 1'b1;
      in_ch     = ch;
      fir_lp_in = x;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      if (!out_valid) begin
         lat = -1;
      end
   endtask

   task automatic run(input string tag, input logic [2:0] ch,
                      input logic [11:0] x, input int exp_y);
      int lat;
      send(ch, x);
      wait_out(lat);
      chk({tag, "_lat"}, lat, 13);
      chk(tag, $signed(fir_lp_out), exp_y);
      chk({tag, "_ch"}, out_ch, ch);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int seen;
      sys_rstn  = 1'b0;
      fir_lp_in = 12'd0;
      in_ch     = 3'd0;
      in_valid  = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_out", fir_lp_out, 0);
      chk("rst_ch", out_ch, 0);
      chk("rst_err", ch_err, 0);
      chk("rst_ready", in_ready, 1);
      sys_rstn = 1'b1;
      tick();

      // impulse response on ch0
      for (int i = 0; i < 9; i++) begin
         run($sformatf("imp%0d", i), 3'd0, (i == 0) ? 12'd1 : 12'd0, imp_exp[i]);
      end

      // saturation, positive then negative full scale
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 8; i++) begin
         run($sformatf("satp%0d", i), 3'd0, 12'h7FF, pos_exp[i]);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 8; i++) begin
         run($sformatf("satn%0d", i), 3'd0, 12'h800, neg_exp[i]);
      end

      // channel isolation
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 8; i++) begin
         run($sformatf("iso0_%0d", i), 3'd0, (i == 0) ? 12'd100 : 12'd0, iso_exp[i]);
         run($sformatf("iso1_%0d", i), 3'd1, 12'd0, 0);
      end

      // backpressure with a pending input sample
      clr = 1'b1;
      tick();
      clr = 1'b0;
      out_ready = 1'b0;
      send(3'd0, 12'd5);
      wait_out(lat);
      chk("bp_lat", lat, 13);
      chk("bp_first", $signed(fir_lp_out), 5);
      in_valid  = 1'b1;
      in_ch     = 3'd0;
      fir_lp_in = 12'd7;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("bp_hold_valid%0d", i), out_valid, 1);
         chk($sformatf("bp_hold_out%0d", i), $signed(fir_lp_out), 5);
         chk($sformatf("bp_hold_ready%0d", i), in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release", out_valid, 0);
      tick();
      in_valid = 1'b0;
      wait_out(lat);
      chk("bp_next_lat", lat, 13);
      chk("bp_next", $signed(fir_lp_out), 17);
      tick();

      // clear in the middle of a computation
      send(3'd0, 12'd50);
      repeat (4) tick();
      clr = 1'b1;
      #1;
      chk("clr_ready", in_ready, 0);
      tick();
      clr  = 1'b0;
      seen = 0;
      repeat (20) begin
         tick();
         if (out_valid) seen++;
      end
      chk("clr_no_out", seen, 0);
      run("clr_hist", 3'd0, 12'd1, 1);

      // out-of-range channel
      send(3'd3, 12'd99);
      chk("cherr_pulse", ch_err, 1);
      chk("cherr_idle", in_ready, 1);
      tick();
      chk("cherr_drop", ch_err, 0);
      chk("cherr_noout", out_valid, 0);
      run("cherr_ch0", 3'd0, 12'd0, 2);
      run("cherr_ch1", 3'd1, 12'd0, 0);

      // asynchronous reset while holding a result
      out_ready = 1'b0;
      send(3'd0, 12'd9);
      wait_out(lat);
      chk("rsth_pre", $signed(fir_lp_out), 12);
      #2;
      sys_rstn = 1'b0;
      #1;
      chk("rsth_valid", out_valid, 0);
      chk("rsth_out", fir_lp_out, 0);
      @(negedge sys_clk);
      sys_rstn  = 1'b1;
      out_ready = 1'b1;
      tick();
      run("rsth_imp", 3'd0, 12'd1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fir_da_mch.md
FIR_DA_MCH -- requirements
Module: fir_da_mch

Interface
REQ-001 SHALL have parameter IDATA_WIDTH, default 12, meaning input sample width (two's complement).
REQ-002 SHALL have parameter ODATA_WIDTH, default 16, meaning output sample width (two's complement).
REQ-003 SHALL have parameter NCH, default 2, meaning number of independent channels (1..8).
REQ-004 SHALL have parameter OUT_SHIFT, default 0, meaning right-shift applied to the accumulator before saturation.
REQ-005 SHALL have port sys_clk, input, 1 bit, the single clock; all logic rising-edge.
REQ-006 SHALL have port sys_rstn, input, 1 bit, reset; asynchronous, active-low.
REQ-007 SHALL have port fir_lp_in, input, IDATA_WIDTH bits, input sample.
REQ-008 SHALL have port in_ch, input, 3 bits, channel index of fir_lp_in.
REQ-009 SHALL have port in_valid, input, 1 bit; port in_ready, output, 1 bit; together the input handshake.
REQ-010 SHALL have port clr, input, 1 bit, synchronous clear of all channel histories.
REQ-011 SHALL have port fir_lp_out, output, ODATA_WIDTH bits, filtered sample.
REQ-012 SHALL have port out_ch, output, 3 bits, channel of fir_lp_out.
REQ-013 SHALL have port out_valid, output, 1 bit; port out_ready, input, 1 bit; together the output handshake.
REQ-014 SHALL have port ch_err, output, 1 bit, one-cycle pulse on an out-of-range channel.

Function
REQ-015 SHALL implement an 8-tap FIR, y[n] = sum over k=0..7 of C[k]*x[n-k], per channel, independent histories.
REQ-016 SHALL use MSB-first bit-serial distributed arithmetic: one bit-plane per cycle, two 16-entry LUTs (taps 0-3, 4-7), outputs summed.
REQ-017 SHALL use FSM states IDLE, CALC, HOLD; in_ready = 1 only in IDLE and only while clr = 0.
REQ-018 SHALL, on transfer (in_valid & in_ready) with in_ch < NCH, shift the sample into that channel's delay line (x[n] at tap 0), latch the channel, and go IDLE -> CALC.
REQ-019 SHALL, on transfer with in_ch >= NCH, discard the sample, leave all histories unchanged, pulse ch_err for one cycle, and stay in IDLE.
REQ-020 SHALL, in CALC, run exactly IDATA_WIDTH cycles: first (sign) cycle acc = -LUTsum, later cycles acc = 2*acc + LUTsum.
REQ-021 SHALL size acc as ACC_W = IDATA_WIDTH + COEF_WIDTH + 3 bits, with no intermediate overflow.
REQ-022 SHALL go CALC -> HOLD with out_valid = 1 exactly IDATA_WIDTH+1 cycles after the accepting edge.
REQ-023 SHALL drive fir_lp_out = acc >>> OUT_SHIFT (arithmetic), saturated to [-2^(ODATA_WIDTH-1), 2^(ODATA_WIDTH-1)-1].
REQ-024 SHALL hold fir_lp_out, out_ch and out_valid stable in HOLD until out_ready = 1, then go to IDLE with out_valid = 0 on the next cycle.
REQ-025 SHALL, when clr = 1 in any state, zero all delay lines, abort any computation without output, and enter IDLE next cycle; clr wins over a simultaneous in_valid.

Reset
REQ-026 SHALL, on sys_rstn = 0, immediately enter IDLE and zero all delay lines, acc, fir_lp_out, out_ch and out_valid; ch_err = 0.
REQ-027 SHALL, on reset mid-CALC or mid-HOLD, drop the pending result; the first post-reset output reflects only post-reset samples.

Structure
REQ-028 SHALL take COEF_WIDTH (8), NTAPS (8), coefficient array C = {1,2,3,4,4,3,2,1}, state encoding and the LUT-build function from shared package fir_da_pkg.
REQ-029 SHALL contain one sub-module, fir_da_lut: combinational 4-input, 16-entry partial-sum LUT built from four package coefficients, instantiated twice.

Verification
REQ-030 SHALL cover impulse: ch0 fed 1 then zeros -> fir_lp_out 1,2,3,4,4,3,2,1,0; each out_valid exactly 13 cycles after acceptance.
REQ-031 SHALL cover saturation: ch0 fed constant 2047 -> outputs 2047, 6141, ... then 32767 (true 40940); constant -2048 -> final -32768.
REQ-032 SHALL cover channel isolation: interleaved ch0 impulse 100 and ch1 zeros -> ch1 outputs all 0, ch0 outputs 100*C[k].
REQ-033 SHALL cover backpressure: out_ready low for 5 cycles in HOLD -> output stable, in_ready low, no sample lost.
REQ-034 SHALL cover clr mid-CALC and in_ch = 3 with NCH = 2 -> no output and histories zeroed; ch_err single pulse with state unchanged.
REQ-035 SHALL cover async reset asserted in HOLD -> out_valid falls without a clock edge; next ch0 impulse 1 yields 1 with no history.
